parallel_to_serial: RTL

//   Upstream companion of the serial-to-parallel deserializer: takes a width-bit word over a

---
 rtl/p2s_pkg.sv | 9 +
 rtl/p2s_hold_reg.sv | 33 +++
 rtl/parallel_to_serial.sv | 108 ++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// Shared types for the parallel-to-serial block.
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry holding register: parks a word that arrives while the shifter is busy.
module p2s_hold_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o,
  output logic             valid_o
);

  logic [width-1:0] data_q;
  logic             valid_q;

  // Load only happens while empty and take only while full, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end
      valid_q <= load_i || (valid_q && !take_i);
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bitstream serializer, LSB first, with valid/ready input and valid/last output.
// Define P2S_SKID_BUF_EN to add a one-word hold register for gapless back-to-back words.
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  output logic             busy
);

  localparam int              CntW    = $clog2(width);
  localparam logic [CntW-1:0] LastCnt = CntW'(width - 1);

  p2s_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic             holdValid;
  logic             transfer;
  logic             lastBit;

  assign transfer = parallel_valid && parallel_ready;
  assign lastBit  = (state_q == SHIFT) && (cnt_q == LastCnt);

`ifdef P2S_SKID_BUF_EN
  logic [width-1:0] holdData;
  logic             holdLoad;
  logic             holdTake;

  assign holdLoad = transfer && (state_q == SHIFT) && !lastBit;
  assign holdTake = lastBit && holdValid;

  p2s_hold_reg #(.width(width)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (holdLoad),
    .take_i (holdTake),
    .data_i (parallel_data),
    .data_o (holdData),
    .valid_o(holdValid)
  );
`else
  assign holdValid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (state_q == IDLE) begin
      if (transfer) begin
        shreg_d = parallel_data;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + CntW'(1);
      if (lastBit) begin
        cnt_d = '0;
`ifdef P2S_SKID_BUF_EN
        // A parked word takes priority; otherwise a word arriving right now chains directly.
        if (holdValid) begin
          shreg_d = holdData;
        end else if (transfer) begin
          shreg_d = parallel_data;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
    end
  end

  always_comb begin
    serial_valid = (state_q == SHIFT);
    serial_data  = (state_q == SHIFT) && shreg_q[0];
    serial_last  = lastBit;
    busy         = (state_q == SHIFT) || holdValid;
`ifdef P2S_SKID_BUF_EN
    parallel_ready = !rst && !holdValid;
`else
    parallel_ready = !rst && (state_q == IDLE);
`endif
  end

endmodule
